// File: rtl/bp_range_buf.sv
// bp_range_buf: two-line, COLS-column BP search-range window fed by 8x2 reconstructed blocks.
// Optional BP_RANGE_PAD_EN fills not-yet-valid columns with each line's oldest valid sample.
module bp_range_buf #(
  parameter int DEPTH = 8,
  parameter int COLS  = 33
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             slice_start,
  input  logic             bp_busy,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic [DEPTH-1:0] rec_line0 [0:7],
  input  logic [DEPTH-1:0] rec_line1 [0:7],
  output logic [DEPTH-1:0] rangec_line0 [0:COLS-1],
  output logic [DEPTH-1:0] rangec_line1 [0:COLS-1],
  output logic [5:0]       range_cnt,
  output logic             range_upd
);
  localparam logic [DEPTH-1:0] MID = {1'b1, {(DEPTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, INIT, ACTIVE} state_t;
  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             upd_q;
  logic             accept;
  logic [DEPTH-1:0] w0_q [0:COLS-1];
  logic [DEPTH-1:0] w1_q [0:COLS-1];
  logic [DEPTH-1:0] n0 [0:COLS-1];
  logic [DEPTH-1:0] n1 [0:COLS-1];
  assign rec_ready = (state_q == ACTIVE) && !bp_busy && !slice_start;
  assign accept    = rec_valid && rec_ready;
  assign state_d   = slice_start ? INIT : (state_q == INIT ? ACTIVE : state_q);
  assign cnt_d     = (cnt_q > 6'(COLS - 8)) ? 6'(COLS) : cnt_q + 6'd8;
  always_comb begin
    for (int i = 0; i < COLS - 8; i++) begin
      n0[i] = w0_q[i+8];
      n1[i] = w1_q[i+8];
    end
    for (int j = 0; j < 8; j++) begin
      n0[COLS-8+j] = rec_line0[j];
      n1[COLS-8+j] = rec_line1[j];
    end
`ifdef BP_RANGE_PAD_EN
    // oldest valid column after the shift sits at COLS-cnt_d
    begin
      logic [DEPTH-1:0] p0, p1;
      p0 = n0[6'(COLS) - cnt_d];
      p1 = n1[6'(COLS) - cnt_d];
      for (int i = 0; i < COLS; i++)
        if (i + int'(cnt_d) < COLS) begin
          n0[i] = p0;
          n1[i] = p1;
        end
    end
`endif
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        w0_q[i] <= '0;
        w1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      upd_q   <= slice_start || accept;
      if (slice_start) begin
        cnt_q <= '0;
        for (int i = 0; i < COLS; i++) begin
          w0_q[i] <= MID;
          w1_q[i] <= MID;
        end
      end else if (accept) begin
        cnt_q <= cnt_d;
        w0_q  <= n0;
        w1_q  <= n1;
      end
    end
  end
  assign rangec_line0 = w0_q;
  assign rangec_line1 = w1_q;
  assign range_cnt    = cnt_q;
  assign range_upd    = upd_q;
endmodule

// File: tb/tb_bp_range_buf.sv
// tb_bp_range_buf: table-driven stream checks plus directed busy, slice-restart, reset and padding sequences.
module tb_bp_range_buf;
  logic       clk, rstn, slice_start, bp_busy, rec_valid, rec_ready, range_upd;
  logic [7:0] rec_line0 [0:7];
  logic [7:0] rec_line1 [0:7];
  logic [7:0] r0 [0:32];
  logic [7:0] r1 [0:32];
  logic [5:0] range_cnt;
  int         n_cmp = 0, n_bad = 0;
`ifdef BP_RANGE_PAD_EN
  localparam int PADV = 0;
  localparam bit PAD  = 1;
`else
  localparam int PADV = 128;
  localparam bit PAD  = 0;
`endif
  typedef struct {int base; int cnt; int l0_0; int l0_25; int l1_32;} vec_t;
  vec_t tv [5];
  bp_range_buf dut (
    .clk(clk), .rstn(rstn), .slice_start(slice_start), .bp_busy(bp_busy),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_line0(rec_line0), .rec_line1(rec_line1),
    .rangec_line0(r0), .rangec_line1(r1), .range_cnt(range_cnt), .range_upd(range_upd)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic blk(input int b0, input int b1);
    for (int j = 0; j < 8; j++) begin
      rec_line0[j] = 8'(b0 + j);
      rec_line1[j] = 8'(b1 + j);
    end
  endtask
  task automatic all_mid(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 33; i++) bad += int'(r0[i] != 8'd128) + int'(r1[i] != 8'd128);
    chk(name, bad, 0);
  endtask
  task automatic start_slice;
    slice_start = 1;
    step();
    slice_start = 0;
    step();
  endtask
  initial begin
    tv[0] = '{0,  8,  PADV, 0,  107};
    tv[1] = '{10, 16, PADV, 10, 117};
    tv[2] = '{20, 24, PADV, 20, 127};
    tv[3] = '{30, 32, PADV, 30, 137};
    tv[4] = '{40, 33, 7,    40, 147};
    rstn = 1; slice_start = 0; bp_busy = 0; rec_valid = 0;
    blk(0, 0);
    #2 rstn = 0;
    #2;
    chk("rst_ready", int'(rec_ready), 0);
    chk("rst_cnt", int'(range_cnt), 0);
    chk("rst_upd", int'(range_upd), 0);
    chk("rst_l0_0", int'(r0[0]), 0);
    chk("rst_l1_32", int'(r1[32]), 0);
    step();
    rstn = 1;
    step();
    chk("idle_ready", int'(rec_ready), 0);
    slice_start = 1;
    step();
    slice_start = 0;
    #1;
    all_mid("init_mid");
    chk("init_cnt", int'(range_cnt), 0);
    chk("init_upd", int'(range_upd), 1);
    chk("init_ready", int'(rec_ready), 0);
    step();
    chk("act_upd", int'(range_upd), 0);
    chk("act_ready", int'(rec_ready), 1);
    for (int n = 0; n < 5; n++) begin
      rec_valid = 1;
      blk(tv[n].base, 100 + tv[n].base);
      #1;
      chk("str_ready", int'(rec_ready), 1);
      step();
      chk("str_cnt", int'(range_cnt), tv[n].cnt);
      chk("str_upd", int'(range_upd), 1);
      chk("str_l0_0", int'(r0[0]), tv[n].l0_0);
      chk("str_l0_25", int'(r0[25]), tv[n].l0_25);
      chk("str_l1_32", int'(r1[32]), tv[n].l1_32);
    end
    for (int i = 0; i < 8; i++) chk("str_tail", int'(r0[25+i]), 40 + i);
    rec_valid = 0;
    step();
    chk("hold_upd", int'(range_upd), 0);
    chk("hold_cnt", int'(range_cnt), 33);
    bp_busy = 1; rec_valid = 1;
    blk(50, 150);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("busy_ready", int'(rec_ready), 0);
      step();
      chk("busy_cnt", int'(range_cnt), 33);
      chk("busy_upd", int'(range_upd), 0);
      chk("busy_l0_32", int'(r0[32]), 47);
    end
    bp_busy = 0;
    #1;
    chk("unbusy_ready", int'(rec_ready), 1);
    step();
    chk("unbusy_l0_32", int'(r0[32]), 57);
    chk("unbusy_l0_25", int'(r0[25]), 50);
    chk("unbusy_upd", int'(range_upd), 1);
    rec_valid = 0;
    start_slice();
    rec_valid = 1;
    blk(60, 160);
    step();
    blk(70, 170);
    step();
    chk("ss_pre_cnt", int'(range_cnt), 16);
    blk(80, 180);
    slice_start = 1;
    #1;
    chk("ss_ready", int'(rec_ready), 0);
    step();
    slice_start = 0;
    #1;
    all_mid("ss_mid");
    chk("ss_cnt", int'(range_cnt), 0);
    chk("ss_upd", int'(range_upd), 1);
    step();
    chk("ss_act_ready", int'(rec_ready), 1);
    chk("ss_act_cnt", int'(range_cnt), 0);
    step();
    chk("ss_acc_cnt", int'(range_cnt), 8);
    chk("ss_acc_l0_32", int'(r0[32]), 87);
    chk("ss_acc_l1_25", int'(r1[25]), 180);
    blk(90, 190);
    step();
    chk("rs_pre_cnt", int'(range_cnt), 16);
    rstn = 0;
    #1;
    chk("rs_cnt", int'(range_cnt), 0);
    chk("rs_upd", int'(range_upd), 0);
    chk("rs_ready", int'(rec_ready), 0);
    chk("rs_l0_32", int'(r0[32]), 0);
    step();
    rstn = 1;
    step();
    step();
    chk("rs_idle_ready", int'(rec_ready), 0);
    chk("rs_idle_cnt", int'(range_cnt), 0);
    chk("rs_idle_l1_0", int'(r1[0]), 0);
    rec_valid = 0;
    start_slice();
    rec_valid = 1;
    blk(5, 205);
    step();
    rec_valid = 0;
    chk("pad_cnt", int'(range_cnt), 8);
    chk("pad_l0_0", int'(r0[0]), PAD ? 5 : 128);
    chk("pad_l0_24", int'(r0[24]), PAD ? 5 : 128);
    chk("pad_l1_10", int'(r1[10]), PAD ? 205 : 128);
    chk("pad_l0_25", int'(r0[25]), 5);
    chk("pad_l0_32", int'(r0[32]), 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
